uart_fifo_io: RTL and testbench

//  Memory-mapped UART port with parametrised RX/TX FIFOs, sticky error flags and a status register.

---
 rtl/uart_fifo_io.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_io.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_io.sv
// ============================================================================
//  Module   : uart_fifo_io (with uarttx / uartrx serial engines)
//  Purpose  : Memory-mapped UART with RX/TX byte FIFOs, sticky error flags
//             and a status register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uarttx #(
   parameter int unsigned ClockFrequencyHz = 20_250_000,
   parameter int unsigned BaudRate         = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_i,
   input  logic       go_i,
   output logic       bsy_o,
   output logic       tx_o
);
   localparam logic [15:0] c_bit_last = 16'(ClockFrequencyHz / BaudRate - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
   state_t      state_q, state_d;
   logic [15:0] baud_q;
   logic [3:0]  bit_q;
   logic [8:0]  sh_q;
   logic        tx_q;
   logic        w_tick;
   logic        w_last;

   assign w_tick = (baud_q == c_bit_last);
   assign w_last = w_tick && (bit_q == 4'd9);
   // bsy drops on the final stop-bit cycle so the next frame can be queued early
   assign bsy_o  = (state_q == S_SHIFT) && !w_last;
   assign tx_o   = tx_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (go_i)   state_d = S_SHIFT;
         S_SHIFT: if (w_last) state_d = S_DONE;
         S_DONE:  if (!go_i)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '1;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && go_i) begin
            sh_q   <= {1'b1, data_i};
            tx_q   <= 1'b0;
            baud_q <= '0;
            bit_q  <= '0;
         end else if (state_q == S_SHIFT) begin
            if (w_tick) begin
               baud_q <= '0;
               if (bit_q != 4'd9) begin
                  tx_q  <= sh_q[0];
                  sh_q  <= {1'b1, sh_q[8:1]};
                  bit_q <= bit_q + 4'd1;
               end
            end else begin
               baud_q <= baud_q + 16'd1;
            end
         end
      end
   end
endmodule

module uartrx #(
   parameter int unsigned ClockFrequencyHz = 20_250_000,
   parameter int unsigned BaudRate         = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   input  logic       go_i,
   output logic [7:0] data_o,
   output logic       ready_o
);
   localparam logic [15:0] c_bit_last = 16'(ClockFrequencyHz / BaudRate - 1);
   localparam logic [15:0] c_half     = 16'(ClockFrequencyHz / BaudRate / 2 - 1);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} state_t;
   state_t      state_q, state_d;
   logic        rx_meta_q, rx_q;
   logic [15:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  sh_q, data_q;
   logic        ready_q;
   logic        w_tick;

   assign w_tick  = (baud_q == c_bit_last);
   assign data_o  = data_q;
   assign ready_o = ready_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         R_IDLE:  if (!rx_q) state_d = R_START;
         R_START: if (baud_q == c_half) state_d = rx_q ? R_IDLE : R_DATA;
         R_DATA:  if (w_tick && bit_q == 3'd7) state_d = R_STOP;
         R_STOP:  if (w_tick) state_d = R_IDLE;
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= R_IDLE;
         rx_meta_q <= 1'b1;
         rx_q      <= 1'b1;
         baud_q    <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_i;
         rx_q      <= rx_meta_q;
         case (state_q)
            R_IDLE:  baud_q <= '0;
            R_START: begin
               if (baud_q == c_half) begin
                  baud_q <= '0;
                  bit_q  <= '0;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: baud_q <= w_tick ? 16'd0 : baud_q + 16'd1;
         endcase
         if (state_q == R_DATA && w_tick) begin
            sh_q  <= {rx_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
         end
         // a freshly completed frame takes priority over the consumer's ack
         if (state_q == R_STOP && w_tick && rx_q) begin
            data_q  <= sh_q;
            ready_q <= 1'b1;
         end else if (!go_i) begin
            ready_q <= 1'b0;
         end
      end
   end
endmodule

module uart_fifo_io #(
   parameter int unsigned ClockFrequencyHz = 20_250_000,
   parameter int unsigned BaudRate         = 9600,
   parameter int unsigned AddressBitWidth  = 32,
   parameter int unsigned DataBitWidth     = 32,
   parameter int unsigned TxDepthLog2      = 4,
   parameter int unsigned RxDepthLog2      = 4,
   parameter logic [AddressBitWidth-1:0] AddressUartOut    = 32'hffff_fff8,
   parameter logic [AddressBitWidth-1:0] AddressUartIn     = 32'hffff_fff4,
   parameter logic [AddressBitWidth-1:0] AddressUartStatus = 32'hffff_ffe4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [2:0]                 read_type,
   input  logic [1:0]                 write_type,
   input  logic [AddressBitWidth-1:0] address,
   input  logic [DataBitWidth-1:0]    data_in,
   output logic [DataBitWidth-1:0]    data_out,
   output logic                       hit,
   output logic                       uart_tx,
   input  logic                       uart_rx
);
   localparam int unsigned c_tx_depth = 1 << TxDepthLog2;
   localparam int unsigned c_rx_depth = 1 << RxDepthLog2;
   localparam int unsigned c_tx_cw    = TxDepthLog2 + 1;
   localparam int unsigned c_rx_cw    = RxDepthLog2 + 1;
   localparam logic [TxDepthLog2:0] c_tx_full = {1'b1, {TxDepthLog2{1'b0}}};
   localparam logic [RxDepthLog2:0] c_rx_full = {1'b1, {RxDepthLog2{1'b0}}};

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_SEND = 2'd2, TX_ACK = 2'd3} tx_state_t;
   tx_state_t tx_state_q, tx_state_d;

   logic [7:0]               tx_mem_q [0:c_tx_depth-1];
   logic [7:0]               rx_mem_q [0:c_rx_depth-1];
   logic [TxDepthLog2-1:0]   tx_wptr_q, tx_rptr_q;
   logic [RxDepthLog2-1:0]   rx_wptr_q, rx_rptr_q;
   logic [TxDepthLog2:0]     tx_cnt_q, tx_cnt_d;
   logic [RxDepthLog2:0]     rx_cnt_q, rx_cnt_d;
   logic                     rx_ovr_q, tx_ovf_q;
   logic                     tx_go_q, tx_go_d, rx_go_q;
   logic [7:0]               tx_byte_q;
   logic                     rd_stb_q, wr_stb_q;
   logic [AddressBitWidth-1:0] addr_q;
   logic [DataBitWidth-1:0]  rd_hold_q;

   logic w_rd_stb, w_wr_stb, w_addr_chg, w_rd_first, w_wr_first;
   logic w_sel_out, w_sel_in, w_sel_st;
   logic w_tx_pop, w_tx_push_req, w_tx_push, w_tx_full, w_tx_bsy;
   logic w_rx_pop, w_rx_push_req, w_rx_push, w_rx_full, w_rx_ready;
   logic w_stat_wr;
   logic [7:0]  w_rx_byte;
   logic [18:0] w_status;
   logic [DataBitWidth-1:0] w_rd_val;
   logic w_unused_data;

   assign w_sel_out  = (address == AddressUartOut);
   assign w_sel_in   = (address == AddressUartIn);
   assign w_sel_st   = (address == AddressUartStatus);
   assign hit        = w_sel_out | w_sel_in | w_sel_st;

   // a multi-cycle access acts only on its first cycle or when the address moves
   assign w_rd_stb   = enable & (read_type != 3'b000);
   assign w_wr_stb   = enable & (write_type != 2'b00);
   assign w_addr_chg = (address != addr_q);
   assign w_rd_first = w_rd_stb & (!rd_stb_q | w_addr_chg);
   assign w_wr_first = w_wr_stb & (!wr_stb_q | w_addr_chg);

   assign w_tx_full     = (tx_cnt_q == c_tx_full);
   assign w_tx_push_req = w_wr_first & w_sel_out;
   assign w_tx_push     = w_tx_push_req & (!w_tx_full | w_tx_pop);

   assign w_rx_full     = (rx_cnt_q == c_rx_full);
   assign w_rx_pop      = w_rd_first & w_sel_in & (rx_cnt_q != '0);
   assign w_rx_push_req = w_rx_ready & rx_go_q;
   assign w_rx_push     = w_rx_push_req & (!w_rx_full | w_rx_pop);

   assign w_stat_wr     = w_wr_first & w_sel_st;
   assign w_status      = {(tx_state_q != TX_IDLE), tx_ovf_q, rx_ovr_q, 8'(tx_cnt_q), 8'(rx_cnt_q)};
   assign w_unused_data = ^{data_in[DataBitWidth-1:18], data_in[15:8]};

   always_comb begin
      w_rd_val = '0;
      if (w_sel_in)
         w_rd_val = (rx_cnt_q != '0) ? DataBitWidth'(rx_mem_q[rx_rptr_q]) : '1;
      else if (w_sel_out)
         w_rd_val = w_tx_full ? '0 : '1;
      else if (w_sel_st)
         w_rd_val = DataBitWidth'(w_status);
   end

   assign data_out = (w_rd_stb & hit) ? (w_rd_first ? w_rd_val : rd_hold_q) : '0;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_go_d    = tx_go_q;
      w_tx_pop   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_cnt_q != '0) begin
               w_tx_pop   = 1'b1;
               tx_go_d    = 1'b1;
               tx_state_d = TX_START;
            end
         end
         TX_START: tx_state_d = TX_SEND;   // bsy is not yet visible here
         TX_SEND: begin
            if (!w_tx_bsy) begin
               tx_go_d    = 1'b0;
               tx_state_d = TX_ACK;
            end
         end
         TX_ACK:  tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      case ({w_tx_push, w_tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + c_tx_cw'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - c_tx_cw'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
      rx_cnt_d = rx_cnt_q;
      case ({w_rx_push, w_rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + c_rx_cw'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - c_rx_cw'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_go_q    <= 1'b0;
         rx_go_q    <= 1'b1;
         tx_byte_q  <= '0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         rx_ovr_q   <= 1'b0;
         tx_ovf_q   <= 1'b0;
         rd_stb_q   <= 1'b0;
         wr_stb_q   <= 1'b0;
         addr_q     <= '0;
         rd_hold_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_go_q    <= tx_go_d;
         rx_go_q    <= !w_rx_push_req;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         rd_stb_q   <= w_rd_stb;
         wr_stb_q   <= w_wr_stb;
         addr_q     <= address;
         if (w_rd_first) rd_hold_q <= w_rd_val;
         if (w_tx_pop) begin
            tx_byte_q <= tx_mem_q[tx_rptr_q];
            tx_rptr_q <= tx_rptr_q + TxDepthLog2'(1);
         end
         if (w_tx_push) tx_wptr_q <= tx_wptr_q + TxDepthLog2'(1);
         if (w_rx_pop)  rx_rptr_q <= rx_rptr_q + RxDepthLog2'(1);
         if (w_rx_push) rx_wptr_q <= rx_wptr_q + RxDepthLog2'(1);
         // a set event in the same cycle as a clear wins
         rx_ovr_q <= (rx_ovr_q & !(w_stat_wr & data_in[16])) | (w_rx_push_req & !w_rx_push);
         tx_ovf_q <= (tx_ovf_q & !(w_stat_wr & data_in[17])) | (w_tx_push_req & !w_tx_push);
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) tx_mem_q[tx_wptr_q] <= data_in[7:0];
      if (w_rx_push) rx_mem_q[rx_wptr_q] <= w_rx_byte;
   end

   uarttx #(
      .ClockFrequencyHz(ClockFrequencyHz),
      .BaudRate        (BaudRate)
   ) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .data_i(tx_byte_q),
      .go_i  (tx_go_q),
      .bsy_o (w_tx_bsy),
      .tx_o  (uart_tx)
   );

   uartrx #(
      .ClockFrequencyHz(ClockFrequencyHz),
      .BaudRate        (BaudRate)
   ) u_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_i   (uart_rx),
      .go_i   (rx_go_q),
      .data_o (w_rx_byte),
      .ready_o(w_rx_ready)
   );
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_io.sv
// ============================================================================
//  Module   : tb_uart_fifo_io
//  Purpose  : Directed self-checking bench for uart_fifo_io (8 clk per bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fifo_io;
   localparam int          CLKS = 8;
   localparam logic [31:0] A_OUT = 32'hffff_fff8;
   localparam logic [31:0] A_IN  = 32'hffff_fff4;
   localparam logic [31:0] A_ST  = 32'hffff_ffe4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  read_type = 3'b000;
   logic [1:0]  write_type = 2'b00;
   logic [31:0] address = 32'h0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] data_out;
   logic        hit;
   logic        uart_tx;
   logic        uart_rx = 1'b1;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  tx_seen [$];

   typedef struct {
      logic [31:0] addr;
      logic        en;
      logic [31:0] exp_d;
      logic        exp_hit;
   } vec_t;
   vec_t vt [6];

   always #5 clk = ~clk;

   uart_fifo_io #(
      .ClockFrequencyHz(1_000_000),
      .BaudRate        (125_000),
      .TxDepthLog2     (2),
      .RxDepthLog2     (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .read_type (read_type),
      .write_type(write_type),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out),
      .hit       (hit),
      .uart_tx   (uart_tx),
      .uart_rx   (uart_rx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      enable = 1'b1; read_type = 3'b010; write_type = 2'b00; address = a;
      #1 d = data_out;
      @(negedge clk);
      enable = 1'b0; read_type = 3'b000;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      enable = 1'b1; write_type = 2'b10; read_type = 3'b000; address = a; data_in = v;
      @(negedge clk);
      enable = 1'b0; write_type = 2'b00;
   endtask

   task automatic send_rx(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = fr[i];
         repeat (CLKS - 1) @(negedge clk);
      end
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k;
      k = 0;
      while (tx_seen.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("tx_frame_count", 32'(tx_seen.size()), 32'(n));
   endtask

   // Serial decoder for uart_tx: samples mid-bit, 8N1
   initial begin : mon_tx
      logic [7:0] b;
      wait (rst_n === 1'b1);
      forever begin
         @(negedge uart_tx);
         repeat (CLKS / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (CLKS) @(negedge clk);
         check("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
         tx_seen.push_back(b);
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] v;
      int          k;

      vt[0] = '{A_IN,          1'b1, 32'hffff_ffff, 1'b1};
      vt[1] = '{A_ST,          1'b1, 32'h0000_0000, 1'b1};
      vt[2] = '{A_OUT,         1'b1, 32'hffff_ffff, 1'b1};
      vt[3] = '{A_IN,          1'b0, 32'h0000_0000, 1'b1};
      vt[4] = '{32'hffff_fff0, 1'b1, 32'h0000_0000, 1'b0};
      vt[5] = '{32'hffff_ffe5, 1'b1, 32'h0000_0000, 1'b0};

      repeat (5) @(negedge clk);
      check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("reset_data_out", data_out, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // reset-state register reads and address decode
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         enable = vt[i].en; read_type = 3'b100; address = vt[i].addr;
         #1;
         check($sformatf("vec%0d_data", i), data_out, vt[i].exp_d);
         check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vt[i].exp_hit});
         @(negedge clk);
         enable = 1'b0; read_type = 3'b000;
      end

      // three bytes out; the first is popped into the transmitter immediately
      wr(A_OUT, 32'h41);
      wr(A_OUT, 32'h42);
      wr(A_OUT, 32'h43);
      rd(A_ST, v);
      check("status_after_abc", v, 32'h0004_0200);
      wait_tx(3, 600);
      check("tx_byte0", {24'b0, tx_seen[0]}, 32'h41);
      check("tx_byte1", {24'b0, tx_seen[1]}, 32'h42);
      check("tx_byte2", {24'b0, tx_seen[2]}, 32'h43);
      repeat (20) @(negedge clk);

      // TX overflow: 1 in flight + 4 queued, 6th byte dropped
      for (int i = 0; i < 6; i++) wr(A_OUT, 32'h10 + 32'(i));
      rd(A_ST, v);
      check("status_tx_full", v, 32'h0006_0400);
      rd(A_OUT, v);
      check("uartout_full", v, 32'h0);
      wait_tx(8, 1000);
      for (int i = 0; i < 5; i++)
         check($sformatf("tx_ovf_byte%0d", i), {24'b0, tx_seen[3 + i]}, 32'h10 + 32'(i));
      repeat (200) @(negedge clk);
      check("tx_no_extra_byte", 32'(tx_seen.size()), 32'd8);
      rd(A_OUT, v);
      check("uartout_space", v, 32'hffff_ffff);

      // RX overrun: 17 frames into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send_rx(8'(i));
      repeat (4) @(negedge clk);
      rd(A_ST, v);
      check("status_rx_full", v, 32'h0003_0010);
      for (int i = 0; i < 16; i++) begin
         rd(A_IN, v);
         check($sformatf("rx_byte%0d", i), v, 32'(i));
      end
      rd(A_IN, v);
      check("rx_empty", v, 32'hffff_ffff);

      // multi-cycle read pops once and holds the first value
      send_rx(8'h55);
      send_rx(8'hAA);
      repeat (4) @(negedge clk);
      @(negedge clk);
      enable = 1'b1; read_type = 3'b001; address = A_IN;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("hold_cycle%0d", i), data_out, 32'h55);
         @(negedge clk);
      end
      enable = 1'b0; read_type = 3'b000;
      rd(A_ST, v);
      check("status_after_hold", v, 32'h0003_0001);
      rd(A_IN, v);
      check("rx_after_hold", v, 32'hAA);

      // selective W1C of rx_overrun only
      wr(A_ST, 32'h0001_0000);
      rd(A_ST, v);
      check("status_w1c_rx", v, 32'h0002_0000);

      // full FIFO, pop coincides with an incoming byte: no overrun
      for (int i = 0; i < 16; i++) send_rx(8'h20 + 8'(i));
      repeat (4) @(negedge clk);
      rd(A_ST, v);
      check("status_refill", v, 32'h0002_0010);
      fork
         send_rx(8'h30);
         begin
            k = 0;
            @(negedge clk);
            while (dut.w_rx_push_req !== 1'b1 && k < 20 * CLKS) begin
               @(negedge clk);
               k++;
            end
            check("push_event_seen", 32'(k < 20 * CLKS), 32'd1);
            enable = 1'b1; read_type = 3'b010; address = A_IN;
            #1 check("coincident_pop", data_out, 32'h20);
            @(negedge clk);
            enable = 1'b0; read_type = 3'b000;
         end
      join
      repeat (4) @(negedge clk);
      rd(A_ST, v);
      check("status_no_overrun", v, 32'h0002_0010);
      wr(A_ST, 32'h0003_0000);
      rd(A_ST, v);
      check("status_w1c_all", v, 32'h0000_0010);
      for (int i = 0; i < 16; i++) begin
         rd(A_IN, v);
         check($sformatf("drain%0d", i), v, 32'h21 + 32'(i));
      end
      rd(A_IN, v);
      check("drain_empty", v, 32'hffff_ffff);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
